// File: rtl/cursor_square_painter.sv
`default_nettype none
// ============================================================================
// Module   : cursor_square_painter
// Purpose  : Pixel source for the VGA controller. Overlays a movable solid
//            square on the background pixel stream inside the 256x256 image
//            window. The square moves and changes colour in response to the
//            debounced buttons. Position and colour change only at the
//            frame tick, so a frame is never drawn with a mix of old and
//            new values.
//
// Ports    : clk         pixel clock (same clock as the VGA counters)
//            rst_n       asynchronous active-low reset
//            i_btn       debounced buttons {up, down, left, right, center}
//            i_hcounter  horizontal counter, 0..799
//            i_vcounter  vertical counter, 0..520
//            i_bg_rgb    background pixel {R,G,B} for the current counters
//            o_vga_rgb   output pixel, registered, one clock latency
//            o_x_pos     square left column, image coordinates
//            o_y_pos     square top row, image coordinates
//            o_color     current square colour
//
// Revision : 1.0  initial release
// ============================================================================
module cursor_square_painter #(
  parameter int SQUARE_SIZE   = 16,   // edge length, power of two, 2..128
  parameter int STEP          = 4,    // pixels per move event
  parameter int REPEAT_FRAMES = 15,   // frames held before each auto-repeat
  parameter int IMG_X0        = 242,  // hcounter value of image column 0
  parameter int IMG_Y0        = 142   // vcounter value of image row 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] i_btn,
  input  logic [9:0] i_hcounter,
  input  logic [9:0] i_vcounter,
  input  logic [2:0] i_bg_rgb,
  output logic [2:0] o_vga_rgb,
  output logic [7:0] o_x_pos,
  output logic [7:0] o_y_pos,
  output logic [2:0] o_color
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Largest legal top-left coordinate: keeps the whole square in the image.
  localparam logic [8:0]  c_MAX_POS   = 9'(256 - SQUARE_SIZE);
  localparam logic [7:0]  c_INIT_POS  = 8'((256 - SQUARE_SIZE) / 2);
  localparam logic [8:0]  c_STEP      = 9'(STEP);
  localparam logic [8:0]  c_SQ        = 9'(SQUARE_SIZE);
  localparam logic [4:0]  c_REPEAT    = 5'(REPEAT_FRAMES);
  localparam logic [2:0]  c_COLOR_RST = 3'b100;

  // Image window bounds, widened so the +256 end never wraps.
  localparam logic [10:0] c_X_LO = 11'(IMG_X0);
  localparam logic [10:0] c_X_HI = 11'(IMG_X0 + 256);
  localparam logic [10:0] c_Y_LO = 11'(IMG_Y0);
  localparam logic [10:0] c_Y_HI = 11'(IMG_Y0 + 256);

  // Last pixel of the frame: the tick is aligned to it.
  localparam logic [9:0]  c_H_LAST = 10'd799;
  localparam logic [9:0]  c_V_LAST = 10'd520;

  // Bit positions inside the button vector.
  localparam int c_BTN_UP     = 4;
  localparam int c_BTN_DOWN   = 3;
  localparam int c_BTN_LEFT   = 2;
  localparam int c_BTN_RIGHT  = 1;
  localparam int c_BTN_CENTER = 0;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [4:0] r_btn_prev;   // button levels one cycle ago, for edge detect
  logic [4:0] r_pend;       // presses collected since the last tick
  logic [4:0] r_hold;       // frames a direction has been held
  logic [7:0] r_x_pos;
  logic [7:0] r_y_pos;
  logic [2:0] r_color;
  logic [2:0] r_vga_rgb;

  // --------------------------------------------------------------------------
  // Combinational wires
  // --------------------------------------------------------------------------
  logic       w_tick;
  logic [4:0] w_press;
  logic       w_any_dir;
  logic       w_repeat;
  logic [3:0] w_rep_mask;
  logic [3:0] w_move;       // {up, down, left, right} applied at this tick
  logic [7:0] w_x_next;
  logic [7:0] w_y_next;
  logic [2:0] w_color_next;
  logic       w_in_img;
  logic [7:0] w_px;
  logic [7:0] w_py;
  logic       w_in_sq;

  // --------------------------------------------------------------------------
  // Saturating single-axis step. 'inc' and 'dec' together cancel out.
  // Arithmetic is done one bit wider than the coordinate so neither the
  // upper nor the lower bound can wrap around.
  // --------------------------------------------------------------------------
  function automatic logic [7:0] f_step(input logic [7:0] pos,
                                        input logic       inc,
                                        input logic       dec);
    logic [8:0] v_sum;
    logic [8:0] v_diff;
    logic [7:0] v_res;
    v_sum  = {1'b0, pos} + c_STEP;
    v_diff = {1'b0, pos} - c_STEP;
    v_res  = pos;
    if (inc && !dec) begin
      v_res = (v_sum > c_MAX_POS) ? c_MAX_POS[7:0] : v_sum[7:0];
    end else if (dec && !inc) begin
      v_res = ({1'b0, pos} >= c_STEP) ? v_diff[7:0] : 8'd0;
    end
    return v_res;
  endfunction

  // --------------------------------------------------------------------------
  // Frame tick, edge detect and move decision
  // --------------------------------------------------------------------------
  always_comb begin
    w_tick     = (i_hcounter == c_H_LAST) && (i_vcounter == c_V_LAST);
    w_press    = i_btn & ~r_btn_prev;
    w_any_dir  = |i_btn[c_BTN_UP:c_BTN_RIGHT];
    // Auto-repeat fires when the hold counter has reached its threshold at a
    // tick; the directions still held at that instant are the ones repeated.
    w_repeat   = w_tick && w_any_dir && (r_hold == c_REPEAT);
    w_rep_mask = w_repeat ? i_btn[c_BTN_UP:c_BTN_RIGHT] : 4'b0000;
    w_move     = r_pend[c_BTN_UP:c_BTN_RIGHT] | w_rep_mask;
  end

  always_comb begin
    w_x_next     = f_step(r_x_pos, w_move[c_BTN_RIGHT - 1], w_move[c_BTN_LEFT - 1]);
    w_y_next     = f_step(r_y_pos, w_move[c_BTN_DOWN - 1],  w_move[c_BTN_UP - 1]);
    // Colour cycles 1..7 and skips black so the square is always visible.
    w_color_next = (r_color == 3'd7) ? 3'd1 : (r_color + 3'd1);
  end

  // --------------------------------------------------------------------------
  // Pixel position and hit test
  // --------------------------------------------------------------------------
  always_comb begin
    w_in_img = ({1'b0, i_hcounter} >= c_X_LO) && ({1'b0, i_hcounter} < c_X_HI) &&
               ({1'b0, i_vcounter} >= c_Y_LO) && ({1'b0, i_vcounter} < c_Y_HI);
    // Only the low 8 bits matter: inside the window the offset is 0..255.
    w_px     = 8'(i_hcounter - 10'(IMG_X0));
    w_py     = 8'(i_vcounter - 10'(IMG_Y0));
    // 9-bit compare: the far edge of the square can equal 256.
    w_in_sq  = w_in_img &&
               ({1'b0, w_px} >= {1'b0, r_x_pos}) &&
               ({1'b0, w_px} <  ({1'b0, r_x_pos} + c_SQ)) &&
               ({1'b0, w_py} >= {1'b0, r_y_pos}) &&
               ({1'b0, w_py} <  ({1'b0, r_y_pos} + c_SQ));
  end

  // --------------------------------------------------------------------------
  // Button edge register and pending mask
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_prev <= 5'b00000;
      r_pend     <= 5'b00000;
    end else begin
      r_btn_prev <= i_btn;
      // At the tick the collected presses are consumed; a press landing in
      // the tick cycle itself starts the next frame's collection.
      if (w_tick) begin
        r_pend <= w_press;
      end else begin
        r_pend <= r_pend | w_press;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Hold counter for auto-repeat
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= 5'd0;
    end else if (w_tick) begin
      if (!w_any_dir) begin
        r_hold <= 5'd0;
      end else if (r_hold == c_REPEAT) begin
        r_hold <= 5'd0;
      end else begin
        r_hold <= r_hold + 5'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Position and colour, updated only at the frame tick
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_pos <= c_INIT_POS;
      r_y_pos <= c_INIT_POS;
      r_color <= c_COLOR_RST;
    end else if (w_tick) begin
      r_x_pos <= w_x_next;
      r_y_pos <= w_y_next;
      if (r_pend[c_BTN_CENTER]) begin
        r_color <= w_color_next;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output pixel register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vga_rgb <= 3'b000;
    end else begin
      r_vga_rgb <= w_in_sq ? r_color : i_bg_rgb;
    end
  end

  assign o_vga_rgb = r_vga_rgb;
  assign o_x_pos   = r_x_pos;
  assign o_y_pos   = r_y_pos;
  assign o_color   = r_color;

endmodule
`default_nettype wire

// File: tb/tb_cursor_square_painter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cursor_square_painter
// Purpose  : Directed self-checking bench for cursor_square_painter. The
//            VGA counters are driven directly, so a "frame" is a jump to the
//            tick position for one clock.
// Revision : 1.0  initial release
// ============================================================================
module tb_cursor_square_painter;

  localparam logic [4:0] c_UP     = 5'b10000;
  localparam logic [4:0] c_DOWN   = 5'b01000;
  localparam logic [4:0] c_LEFT   = 5'b00100;
  localparam logic [4:0] c_RIGHT  = 5'b00010;
  localparam logic [4:0] c_CENTER = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn;
  logic [9:0] hc;
  logic [9:0] vc;
  logic [2:0] bg;
  logic [2:0] vga_rgb;
  logic [7:0] x_pos;
  logic [7:0] y_pos;
  logic [2:0] color;

  always #5 clk = ~clk;

  cursor_square_painter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_btn      (btn),
    .i_hcounter (hc),
    .i_vcounter (vc),
    .i_bg_rgb   (bg),
    .o_vga_rgb  (vga_rgb),
    .o_x_pos    (x_pos),
    .o_y_pos    (y_pos),
    .o_color    (color)
  );

  typedef struct {
    string tag;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic push(input string tag, input int e);
    exp_t it;
    it.tag = tag;
    it.exp = e;
    sb.push_back(it);
  endtask

  task automatic pop_check(input int obs);
    exp_t it;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", it.tag, obs, it.exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    hc = 10'd799;
    vc = 10'd520;
    cyc(1);
    hc = 10'd0;
    vc = 10'd0;
  endtask

  task automatic press(input logic [4:0] b);
    btn = b;
    cyc(1);
    btn = 5'b0;
    cyc(1);
  endtask

  task automatic frame_move(input logic [4:0] b);
    press(b);
    tick();
  endtask

  // Drive a counter pair and compare the pixel one clock later.
  task automatic pix(input string tag, input int h, input int v,
                     input logic [2:0] b, input int e);
    hc = 10'(h);
    vc = 10'(v);
    bg = b;
    push(tag, e);
    cyc(1);
    pop_check(int'(vga_rgb));
  endtask

  initial begin
    int col_seq[8];
    col_seq = '{5, 6, 7, 1, 2, 3, 4, 5};

    rst_n = 1'b0;
    btn   = 5'b0;
    hc    = 10'd300;
    vc    = 10'd300;
    bg    = 3'b010;
    #7;
    push("rst_x", 120);     pop_check(int'(x_pos));
    push("rst_y", 120);     pop_check(int'(y_pos));
    push("rst_color", 4);   pop_check(int'(color));
    push("rst_rgb", 0);     pop_check(int'(vga_rgb));

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1);

    // Square at (120,120), colour 100, boundaries on both axes.
    pix("px_inside",      362, 262, 3'b010, 4);
    pix("px_left_out",    361, 262, 3'b010, 2);
    pix("px_right_in",    377, 262, 3'b010, 4);
    pix("px_right_out",   378, 262, 3'b010, 2);
    pix("px_bottom_in",   362, 277, 3'b010, 4);
    pix("px_bottom_out",  362, 278, 3'b010, 2);
    pix("px_outside_img", 100, 100, 3'b011, 3);
    hc = 10'd0;
    vc = 10'd0;

    // Right held 3 cycles, then a second press in the same frame.
    btn = c_RIGHT;
    cyc(3);
    btn = 5'b0;
    cyc(1);
    push("x_before_tick", 120); pop_check(int'(x_pos));
    press(c_RIGHT);
    push("x_still_before", 120); pop_check(int'(x_pos));
    tick();
    push("x_single_move", 124); pop_check(int'(x_pos));
    tick();
    push("x_no_extra", 124); pop_check(int'(x_pos));

    // Asynchronous reset away from any clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    push("async_rst_x", 120);     pop_check(int'(x_pos));
    push("async_rst_color", 4);   pop_check(int'(color));
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    // Right limit.
    for (int i = 0; i < 29; i++) frame_move(c_RIGHT);
    push("x_236", 236); pop_check(int'(x_pos));
    frame_move(c_RIGHT);
    push("x_240", 240); pop_check(int'(x_pos));
    frame_move(c_RIGHT);
    push("x_sat_240", 240); pop_check(int'(x_pos));

    // Left limit.
    for (int i = 0; i < 60; i++) frame_move(c_LEFT);
    push("x_0", 0); pop_check(int'(x_pos));
    frame_move(c_LEFT);
    push("x_sat_0", 0); pop_check(int'(x_pos));

    // Down held for 40 frames: move at tick 1, repeats at ticks 16 and 32.
    btn = c_DOWN;
    cyc(1);
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 1)  begin push("hold_t1",  124); pop_check(int'(y_pos)); end
      if (t == 15) begin push("hold_t15", 124); pop_check(int'(y_pos)); end
      if (t == 16) begin push("hold_t16", 128); pop_check(int'(y_pos)); end
      if (t == 31) begin push("hold_t31", 128); pop_check(int'(y_pos)); end
      if (t == 32) begin push("hold_t32", 132); pop_check(int'(y_pos)); end
      if (t == 40) begin push("hold_t40", 132); pop_check(int'(y_pos)); end
    end
    btn = 5'b0;
    cyc(1);
    repeat (20) tick();
    push("released_y", 132); pop_check(int'(y_pos));

    // Counter must have cleared on release: 15 more held frames give only
    // the initial move.
    btn = c_DOWN;
    cyc(1);
    repeat (15) tick();
    push("hold_cleared", 136); pop_check(int'(y_pos));
    btn = 5'b0;
    cyc(1);
    tick();
    push("hold_cleared_rel", 136); pop_check(int'(y_pos));

    // Left and right in the same frame cancel.
    repeat (3) frame_move(c_RIGHT);
    push("x_12", 12); pop_check(int'(x_pos));
    frame_move(c_LEFT | c_RIGHT);
    push("lr_same_cycle", 12); pop_check(int'(x_pos));
    press(c_LEFT);
    press(c_RIGHT);
    tick();
    push("lr_same_frame", 12); pop_check(int'(x_pos));

    // Colour cycling from 100.
    for (int i = 0; i < 8; i++) begin
      frame_move(c_CENTER);
      push($sformatf("color_%0d", i), col_seq[i]);
      pop_check(int'(color));
    end

    // Up pressed exactly in the tick cycle is deferred one frame.
    hc  = 10'd799;
    vc  = 10'd520;
    btn = c_UP;
    cyc(1);
    hc  = 10'd0;
    vc  = 10'd0;
    btn = 5'b0;
    cyc(1);
    push("up_at_tick", 136); pop_check(int'(y_pos));
    tick();
    push("up_deferred", 132); pop_check(int'(y_pos));

    // Square now at (12,132), colour 101.
    pix("px2_in",        254, 274, 3'b011, 5);
    pix("px2_left_out",  253, 274, 3'b011, 3);
    pix("px2_right_in",  269, 274, 3'b011, 5);
    pix("px2_right_out", 270, 274, 3'b011, 3);
    pix("px2_bot_in",    254, 289, 3'b011, 5);
    pix("px2_bot_out",   254, 290, 3'b011, 3);

    total++;
    if (sb.size() != 0) begin
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end else begin
      passed++;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cursor_square_painter.md
Name: cursor_square_painter

Overview:
- Pixel source feeding the VGA controller's RGB input: overlays a movable solid square on the background pixel stream inside the 256x256 active image window.
- Square position and colour come from the debounced button vector (up, down, left, right, center). Updates apply only at frame boundaries, so no tearing.
- Sits between the Button block and the VGA controller. Consumes the controller's horizontal and vertical counters.

Parameters:
- SQUARE_SIZE, 16, square edge length in pixels (power of two, 2..128)
- STEP, 4, pixels moved per move event
- REPEAT_FRAMES, 15, frames a direction must be held before each auto-repeat move
- IMG_X0, 242, horizontal counter value of image column 0
- IMG_Y0, 142, vertical counter value of image row 0

Ports:
- Clock  in  1  pixel clock, same clock as the VGA controller counters
- Reset  in  1  asynchronous, active-low reset
- iBTN  in  5  debounced buttons {up, down, left, right, center}, level, 1 = pressed
- iHcounter  in  10  horizontal counter, 0..799
- iVcounter  in  10  vertical counter, 0..520
- iBgRGB  in  3  background pixel {R,G,B} for the current counters
- oVGA_RGB  out  3  output pixel, drives the VGA controller RGB input
- oXPos  out  8  square left column, image coordinates
- oYPos  out  8  square top row, image coordinates
- oColor  out  3  current square colour

Behaviour:
- Reset (Reset low, asynchronous) values:
  - oXPos = oYPos = (256-SQUARE_SIZE)/2, i.e. 120 at default
  - oColor = 3'b100
  - oVGA_RGB = 0
  - edge register, pending mask and hold counter = 0
- Reset asserted mid-frame clears everything immediately. Operation resumes on the first Clock edge after release.
- Frame tick: single-cycle combinational strobe, high when iHcounter==799 && iVcounter==520.
- Edge detect: rBtnPrev <= iBTN every cycle; press = iBTN & ~rBtnPrev.
- Pending mask (5 bits), sticky between ticks:
  - no tick: pend <= pend | press
  - tick: pend <= press (a press coincident with the tick is deferred to the next frame)
- Hold counter (5 bits):
  - on each tick, if any direction bit of iBTN is set: increment
  - if no direction bit is set: clear to 0
  - when it equals REPEAT_FRAMES at a tick: generate repeat mask = iBTN[4:1] and reload the counter to 0
- Applied move mask at tick = pend[4:1] | repeat mask. Left and right both set: no X change. Up and down both set: no Y change.
- X arithmetic:
  - right: X = min(X+STEP, 256-SQUARE_SIZE)
  - left: X = max(X-STEP, 0)
  - compute in 9 bits; never wrap
- Y arithmetic: same rule (down adds, up subtracts).
- Colour: center press (pend[0] at tick) advances the colour 1→2→…→7→1. Colour 000 is never produced. Center has no auto-repeat.
- Pixel path:
  - inImg when IMG_X0 <= iHcounter < IMG_X0+256 and IMG_Y0 <= iVcounter < IMG_Y0+256
  - px = iHcounter-IMG_X0 and py = iVcounter-IMG_Y0, 8 bits each
  - inSq when inImg && oXPos <= px < oXPos+SQUARE_SIZE && oYPos <= py < oYPos+SQUARE_SIZE (compare in 9 bits)
  - oVGA_RGB <= inSq ? oColor : iBgRGB, registered, latency exactly 1 Clock
- The position/colour used for a pixel is the value registered before that pixel's clock edge. Updates at the tick take effect from the next frame's first pixel.

Test Plan:
- Reset low mid-frame, then release → oXPos=120, oYPos=120, oColor=100, oVGA_RGB=000 while low; counters (IMG_X0+120, IMG_Y0+120) with iBgRGB=010 give oVGA_RGB=100 one clock later; (IMG_X0+119, IMG_Y0+120) gives 010.
- Pulse right for 3 cycles mid-frame, then run to tick → oXPos=124 after the tick, unchanged before it; second right press in the same frame is absorbed (single move).
- Start at X=236 (five right moves from 216), press right twice over two frames → X=240 then stays 240; from X=0, left → stays 0.
- Hold down continuously for 40 frames from Y=120 → one move at the first tick after press (124), repeats at ticks 16 and 32 of holding → Y=132; release → counter clears, no further moves.
- Press left and right in the same frame → X unchanged; press center 8 times over 8 frames from 100 → colour sequence 5,6,7,1,2,3,4,5.
- Press up in the exact cycle of the tick → Y unchanged at that tick, Y-4 at the following tick.
